// File: rtl/pipelined_cla_adder_if.sv
// Operand and result handshake bundle for pipelined_cla_adder.
// The master drives operands and out_ready; the slave is the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in1, in2, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, in1, in2, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit.
// Each stage resolves one GROUP-bit lookahead group. WIDTH must be a multiple of GROUP.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input logic                  clock,
    input logic                  reset_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int N = WIDTH / GROUP;

    // Packed as {carry into group MSB, group carry out, group sum}.
    typedef logic [GROUP+1:0] grp_t;

    function automatic grp_t cla_group(input logic [GROUP-1:0] a,
                                       input logic [GROUP-1:0] b,
                                       input logic             c0);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        logic             prod;
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) term = term & p[j];
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int m = j + 1; m <= i; m++) prod = prod & p[m];
                term = term | prod;
            end
            c[i+1] = term;
        end
        return {c[GROUP-1], c[GROUP], a ^ b ^ c[GROUP-1:0]};
    endfunction

    logic             vld_p   [N];
    logic [WIDTH-1:0] a_p     [N];
    logic [WIDTH-1:0] b_p     [N];
    logic [WIDTH-1:0] sum_p   [N];
    logic             c_p     [N];
    logic             zero_p  [N];
    logic             msb_p;
    logic             adv;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    grp_t             grp     [N];

    // in_ready is combinational from out_ready: the single allowed through path.
    assign adv          = !vld_p[N-1] | bus.out_ready;
    assign bus.in_ready = adv;
    assign b_in         = bus.sub ? ~bus.in2 : bus.in2;
    assign c_in         = bus.cin ^ bus.sub;

    always_comb begin
        grp[0] = cla_group(bus.in1[GROUP-1:0], b_in[GROUP-1:0], c_in);
        for (int k = 1; k < N; k++)
            grp[k] = cla_group(a_p[k-1][GROUP-1:0], b_p[k-1][GROUP-1:0], c_p[k-1]);
    end

    // Operands shift right one group per stage; finished sum groups enter at the top
    // and shift right, so group 0 reaches bit 0 as the word leaves the last stage.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                vld_p[k]  <= 1'b0;
                a_p[k]    <= '0;
                b_p[k]    <= '0;
                sum_p[k]  <= '0;
                c_p[k]    <= 1'b0;
                zero_p[k] <= 1'b0;
            end
            msb_p <= 1'b0;
        end else if (adv) begin
            vld_p[0]  <= bus.in_valid;
            a_p[0]    <= bus.in1 >> GROUP;
            b_p[0]    <= b_in >> GROUP;
            sum_p[0]  <= WIDTH'(grp[0][GROUP-1:0]) << (WIDTH - GROUP);
            c_p[0]    <= grp[0][GROUP];
            zero_p[0] <= (grp[0][GROUP-1:0] == '0);
            for (int k = 1; k < N; k++) begin
                vld_p[k]  <= vld_p[k-1];
                a_p[k]    <= a_p[k-1] >> GROUP;
                b_p[k]    <= b_p[k-1] >> GROUP;
                sum_p[k]  <= (sum_p[k-1] >> GROUP)
                           | (WIDTH'(grp[k][GROUP-1:0]) << (WIDTH - GROUP));
                c_p[k]    <= grp[k][GROUP];
                zero_p[k] <= zero_p[k-1] & (grp[k][GROUP-1:0] == '0);
            end
            msb_p <= grp[N-1][GROUP+1];
        end
    end

    assign bus.out_valid = vld_p[N-1];
    assign bus.sum       = sum_p[N-1];
    assign bus.cout      = c_p[N-1];
    assign bus.overflow  = c_p[N-1] ^ msb_p;
    assign bus.zero      = zero_p[N-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder at defaults, plus a width/group sweep
// against a plain-arithmetic reference.
module tb_pipelined_cla_adder;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();
    pipelined_cla_adder_if #(.WIDTH(8))  bus8  ();
    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_adder_if #(.WIDTH(64)) bus64 ();

    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32));
    pipelined_cla_adder #(.WIDTH(8),  .GROUP(8)) dut8  (.clock(clock), .reset_n(reset_n), .bus(bus8));
    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clock(clock), .reset_n(reset_n), .bus(bus16));
    pipelined_cla_adder #(.WIDTH(64), .GROUP(8)) dut64 (.clock(clock), .reset_n(reset_n), .bus(bus64));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: {overflow, cout, zero, sum} from wide integer arithmetic.
    function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic c);
        logic [64:0] mask;
        logic [64:0] aa;
        logic [64:0] bb;
        logic [64:0] full;
        logic [63:0] r;
        logic        co;
        logic        ov;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
        full = aa + bb + {64'd0, c ^ s};
        r    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        return {ov, co, (r == 64'd0), r};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c, input logic [31:0] exp_sum,
                          input logic exp_c, input logic exp_v, input logic exp_z);
        int lat;
        bus32.in1 = a;  bus32.in2 = b;  bus32.sub = s;  bus32.cin = c;
        bus32.in_valid = 1'b1;
        bus32.out_ready = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        lat = 0;
        while (!bus32.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_sum"}, 64'(bus32.sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus32.cout), 64'(exp_c));
        check({tag, "_ovf"}, 64'(bus32.overflow), 64'(exp_v));
        check({tag, "_zero"}, 64'(bus32.zero), 64'(exp_z));
        tick();
    endtask

    task automatic chk_res(input string tag, input logic [66:0] e, input logic [63:0] s,
                           input logic co, input logic ov, input logic z);
        check({tag, "_sum"}, s, e[63:0]);
        check({tag, "_zero"}, 64'(z), 64'(e[64]));
        check({tag, "_cout"}, 64'(co), 64'(e[65]));
        check({tag, "_ovf"}, 64'(ov), 64'(e[66]));
    endtask

    initial begin
        int sent;
        int got;
        int emitted;
        logic [63:0] ra;
        logic [63:0] rb;
        logic rs;
        logic rc;
        logic [66:0] e;
        logic [66:0] q8[$];
        logic [66:0] q16[$];
        logic [66:0] q64[$];

        n_checks = 0;
        n_fail   = 0;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;  bus8.in1 = '0;  bus8.in2 = '0;  bus8.sub = 1'b0;  bus8.cin = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.in1 = '0; bus16.in2 = '0; bus16.sub = 1'b0; bus16.cin = 1'b0;
        bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.in1 = '0; bus64.in2 = '0; bus64.sub = 1'b0; bus64.cin = 1'b0;

        // Reset held two cycles with in_valid asserted
        reset_n = 1'b0;
        bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        bus32.in1 = 32'h1234_5678; bus32.in2 = 32'h1111_1111; bus32.sub = 1'b0; bus32.cin = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_sum", 64'(bus32.sum), 64'd0);
        check("rst_cout", 64'(bus32.cout), 64'd0);
        check("rst_ovf", 64'(bus32.overflow), 64'd0);
        check("rst_zero", 64'(bus32.zero), 64'd0);
        reset_n = 1'b1;
        bus32.in_valid = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        tick();

        // Directed add/sub vectors
        run_op("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("add_mix",   32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0);
        run_op("add_cin",   32'h00FF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        run_op("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_borrow",32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream with a 3-cycle output stall
        sent = 0;
        got  = 0;
        bus32.sub = 1'b0;
        bus32.cin = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            bus32.out_ready = (cyc >= 4 && cyc < 7) ? 1'b0 : 1'b1;
            bus32.in_valid  = (sent < 8);
            bus32.in1 = 32'(sent + 1);
            bus32.in2 = 32'(sent + 1);
            #1;
            if (bus32.out_valid && !bus32.out_ready) begin
                check("bp_stall_in_ready", 64'(bus32.in_ready), 64'd0);
                check("bp_stall_sum", 64'(bus32.sum), 64'(2 * (got + 1)));
            end
            if (bus32.out_valid && bus32.out_ready) begin
                check("bp_sum", 64'(bus32.sum), 64'(2 * (got + 1)));
                got++;
            end
            if (bus32.in_valid && bus32.in_ready) sent++;
            tick();
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        check("bp_received", 64'(got), 64'd8);
        check("bp_sent", 64'(sent), 64'd8);
        tick();
        tick();
        tick();
        tick();
        check("bp_no_dup", 64'(bus32.out_valid), 64'd0);

        // Reset with three operations in flight
        bus32.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus32.in1 = 32'(100 + i);
            bus32.in2 = 32'd1;
            tick();
        end
        bus32.in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        emitted = 0;
        check("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (bus32.out_valid) emitted++;
            tick();
        end
        check("midrst_emitted", 64'(emitted), 64'd0);
        run_op("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0);

        // Width/group sweep against the reference model
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 24) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rs = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                if (cyc == 0) begin ra = '1; rb = 64'd1; rs = 1'b0; rc = 1'b0; end
                if (cyc == 1) begin ra = 64'd0; rb = 64'd1; rs = 1'b1; rc = 1'b0; end
                bus8.in1  = ra[7:0];  bus8.in2  = rb[7:0];  bus8.sub  = rs; bus8.cin  = rc; bus8.in_valid  = 1'b1;
                bus16.in1 = ra[15:0]; bus16.in2 = rb[15:0]; bus16.sub = rs; bus16.cin = rc; bus16.in_valid = 1'b1;
                bus64.in1 = ra;       bus64.in2 = rb;       bus64.sub = rs; bus64.cin = rc; bus64.in_valid = 1'b1;
                q8.push_back(model(8, ra, rb, rs, rc));
                q16.push_back(model(16, ra, rb, rs, rc));
                q64.push_back(model(64, ra, rb, rs, rc));
            end else begin
                bus8.in_valid = 1'b0; bus16.in_valid = 1'b0; bus64.in_valid = 1'b0;
            end
            if (bus8.out_valid) begin
                if (q8.size() == 0) check("sw8_extra", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front();
                    chk_res("sw8", e, 64'(bus8.sum), bus8.cout, bus8.overflow, bus8.zero);
                end
            end
            if (bus16.out_valid) begin
                if (q16.size() == 0) check("sw16_extra", 64'd1, 64'd0);
                else begin
                    e = q16.pop_front();
                    chk_res("sw16", e, 64'(bus16.sum), bus16.cout, bus16.overflow, bus16.zero);
                end
            end
            if (bus64.out_valid) begin
                if (q64.size() == 0) check("sw64_extra", 64'd1, 64'd0);
                else begin
                    e = q64.pop_front();
                    chk_res("sw64", e, bus64.sum, bus64.cout, bus64.overflow, bus64.zero);
                end
            end
            tick();
        end
        check("sw8_left", 64'(q8.size()), 64'd0);
        check("sw16_left", 64'(q16.size()), 64'd0);
        check("sw64_left", 64'(q64.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
